// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package bsa_pkg;
  localparam int BSA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bsa_state_e;
endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder built from discrete XOR/AND/OR terms.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic axb;

  assign axb  = a ^ b;
  assign s    = axb ^ cin;
  assign cout = (a & b) | (cin & axb);
endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder processing one bit pair per clock, LSB first, through one fa_cell.
// Optional signed-overflow flag enabled by defining BSA_OVF_EN.
module bit_serial_adder
  import bsa_pkg::*;
#(
  parameter int WIDTH = BSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  bsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_c, last_bit;
`ifdef BSA_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fa_cell u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_c)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef BSA_OVF_EN
    ovf_d   = ovf_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        done    = (state_q == DONE);
        state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        busy           = 1'b1;
        a_d            = a_q >> 1;
        b_d            = b_q >> 1;
        sum_d          = sum_q >> 1;
        sum_d[WIDTH-1] = fa_s;
        carry_d        = fa_c;
        cnt_d          = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = DONE;
          cout_d  = fa_c;
`ifdef BSA_OVF_EN
          // carry_q here is the carry into the MSB
          ovf_d   = carry_q ^ fa_c;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

`ifdef BSA_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
